// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: takes one SINGLE/INCR4/INCR8/INCR16 command at a time and drives the
// pipelined address/data phases, honouring slave wait states.
module ahb_burst_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_burst,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              cmd_err,
    input  logic              hr_readyout,
    input  logic [DATA_W-1:0] hr_data,
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hwdata,
    output logic              hwrite,
    output logic              hready_in,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst
);

    localparam logic [2:0] MaxSize  = 3'($clog2(DATA_W / 8));
    localparam logic [1:0] TrIdle   = 2'd0;
    localparam logic [1:0] TrNonseq = 2'd2;
    localparam logic [1:0] TrSeq    = 2'd3;

    typedef enum logic [1:0] {StIdle, StAddr, StAddrData, StLastData} state_e;

    state_e            state_q;
    logic              cmd_ready_q, wr_ack_q, rd_valid_q, done_q, cmd_err_q;
    logic              hwrite_q, hready_in_q;
    logic [DATA_W-1:0] rd_data_q, hwdata_q;
    logic [ADDR_W-1:0] haddr_q;
    logic [1:0]        htrans_q;
    logic [2:0]        hsize_q, hburst_q;
    logic [3:0]        left_q;   // address phases still to issue after the one on the bus

    logic [4:0]        beats;
    logic [2:0]        hburst_map;
    logic [ADDR_W-1:0] align_mask;
    logic [12:0]       span_end;
    logic              cmd_bad;

    always_comb begin
        beats      = 5'd1;
        hburst_map = 3'd0;
        unique case (cmd_burst)
            2'd0: begin beats = 5'd1;  hburst_map = 3'd0; end
            2'd1: begin beats = 5'd4;  hburst_map = 3'd3; end
            2'd2: begin beats = 5'd8;  hburst_map = 3'd5; end
            2'd3: begin beats = 5'd16; hburst_map = 3'd7; end
        endcase
        align_mask = (ADDR_W'(1) << cmd_size) - ADDR_W'(1);
        // Last byte offset within the current 1 KB page; anything past 1023 crosses it.
        span_end   = 13'(cmd_addr[9:0]) + (13'(beats) << cmd_size) - 13'd1;
        cmd_bad    = (cmd_size > MaxSize) || ((cmd_addr & align_mask) != '0) ||
                     (span_end > 13'd1023);
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
            hwrite_q    <= 1'b0;
            hready_in_q <= 1'b0;
            rd_data_q   <= '0;
            hwdata_q    <= '0;
            haddr_q     <= '0;
            htrans_q    <= TrIdle;
            hsize_q     <= 3'd0;
            hburst_q    <= 3'd0;
            left_q      <= 4'd0;
        end else begin
            hready_in_q <= 1'b1;
            wr_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        if (cmd_bad) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            state_q     <= StAddr;
                            cmd_ready_q <= 1'b0;
                            htrans_q    <= TrNonseq;
                            haddr_q     <= cmd_addr;
                            hwrite_q    <= cmd_write;
                            hsize_q     <= cmd_size;
                            hburst_q    <= hburst_map;
                            left_q      <= 4'(beats - 5'd1);
                        end
                    end
                end
                StAddr, StAddrData: begin
                    if (hr_readyout) begin
                        // In StAddrData the previous beat's data phase completes on this edge.
                        if (state_q == StAddrData && !hwrite_q) begin
                            rd_data_q  <= hr_data;
                            rd_valid_q <= 1'b1;
                        end
                        if (hwrite_q) begin
                            hwdata_q <= wr_data;
                            wr_ack_q <= 1'b1;
                        end
                        if (left_q == 4'd0) begin
                            htrans_q <= TrIdle;
                            state_q  <= StLastData;
                        end else begin
                            htrans_q <= TrSeq;
                            haddr_q  <= haddr_q + (ADDR_W'(1) << hsize_q);
                            left_q   <= left_q - 4'd1;
                            state_q  <= StAddrData;
                        end
                    end
                end
                StLastData: begin
                    if (hr_readyout) begin
                        if (!hwrite_q) begin
                            rd_data_q  <= hr_data;
                            rd_valid_q <= 1'b1;
                        end
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ack    = wr_ack_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign cmd_err   = cmd_err_q;
    assign haddr     = haddr_q;
    assign hwdata    = hwdata_q;
    assign hwrite    = hwrite_q;
    assign hready_in = hready_in_q;
    assign htrans    = htrans_q;
    assign hsize     = hsize_q;
    assign hburst    = hburst_q;

endmodule
